// File: rtl/bus_pkg.sv
// Shared types and sizing helpers for the serial bus master and its BRAM slave.
package bus_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_ADN = 12;
  localparam int DEF_DELAY_N = 20;

  // The slave discards the address bit carried on the START beat.
  localparam logic START_BEAT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    SHIFT,
    WR_DONE,
    RD_WAIT,
    RD_SHIFT,
    RESP
  } state_t;

  // Bit counter wide enough to hold the value w itself.
  function automatic int addrBits(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic int cntBits(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_piso_sipo.sv
// Multi-lane shift register: parallel load, MSB-first shift-out, LSB shift-in,
// with a counter of shifts since the last load.
module bus_piso_sipo
  import bus_pkg::*;
#(
  parameter int W = 8,
  parameter int LANES = 1,
  parameter int CB = addrBits(W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LANES*W-1:0]   loadData,
  input  logic                 shiftEn,
  input  logic [LANES-1:0]     serIn,
  output logic [LANES-1:0]     serOut,
  output logic [LANES*W-1:0]   parOut,
  output logic [CB-1:0]        bitCnt
);

  logic [LANES-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      bitCnt <= '0;
    end else if (load) begin
      sr <= loadData;
      bitCnt <= '0;
    end else if (shiftEn) begin
      for (int l = 0; l < LANES; l++) begin
        sr[l] <= {sr[l][W-2:0], serIn[l]};
      end
      bitCnt <= bitCnt + 1'b1;
    end
  end

  always_comb begin
    serOut = '0;
    for (int l = 0; l < LANES; l++) begin
      serOut[l] = sr[l][W-1];
    end
  end

  assign parOut = sr;

endmodule

// File: rtl/bus_master_port.sv
// Parallel-to-serial bus master front end for the serial BRAM slave.
// States: IDLE wait req | GRANT wait grant+ready | START start beat | SHIFT addr/wdata beats
//         WR_DONE wait slave commit | RD_WAIT wait preamble | RD_SHIFT capture rdata | RESP pulse
module bus_master_port
  import bus_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int ADN = DEF_ADN,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  input  logic           req_wren,
  input  logic [ADN-1:0] req_addr,
  input  logic [N-1:0]   req_wdata,
  output logic           req_ready,
  output logic           resp_valid,
  output logic [N-1:0]   resp_rdata,
  output logic           resp_err,
  output logic           bus_req,
  input  logic           bus_grant,
  output logic           s_valid,
  output logic           s_wren,
  output logic           s_addr,
  output logic           s_wdata,
  output logic           s_bus_avail,
  input  logic           s_ready,
  input  logic           s_hold,
  input  logic           s_rvalid,
  input  logic           s_rdata
);

  localparam int ADDR_BITS = addrBits(ADN);
  localparam int DATA_BITS = addrBits(N);
  localparam int CNT_BITS = cntBits(TIMEOUT);

  state_t state, stateNext;
  logic wrenL;
  logic [CNT_BITS-1:0] tmo;
  logic tmoInc, timedOut, errNext;
  logic accept, serShift, desShift;
  logic [1:0] serOut;
  logic [ADDR_BITS-1:0] serCnt;
  logic [2*ADN-1:0] unusedSerPar;
  logic [N-1:0] desPar;
  logic [DATA_BITS-1:0] desCnt;
  logic unusedDesOut;
  logic [N-1:0] rdNext;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign timedOut = (tmo == CNT_BITS'(TIMEOUT));
  assign serShift = (stateNext == SHIFT);
  assign desShift = (state == RD_SHIFT) && s_rvalid;

  // Lane 1 carries write data right-aligned so it lands on the last N beats.
  bus_piso_sipo #(.W(ADN), .LANES(2), .CB(ADDR_BITS)) uSer (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .loadData({ADN'(req_wdata), req_addr}),
    .shiftEn(serShift),
    .serIn(2'b00),
    .serOut(serOut),
    .parOut(unusedSerPar),
    .bitCnt(serCnt)
  );

  bus_piso_sipo #(.W(N), .LANES(1), .CB(DATA_BITS)) uDes (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .loadData('0),
    .shiftEn(desShift),
    .serIn(s_rdata),
    .serOut(unusedDesOut),
    .parOut(desPar),
    .bitCnt(desCnt)
  );

  always_comb begin
    stateNext = state;
    errNext = 1'b0;
    tmoInc = 1'b0;
    unique case (state)
      IDLE: if (accept) stateNext = GRANT;
      GRANT: begin
        tmoInc = 1'b1;
        if (bus_grant && s_ready) stateNext = START;
        else if (timedOut) begin
          stateNext = RESP;
          errNext = 1'b1;
        end
      end
      START: stateNext = SHIFT;
      SHIFT: if (serCnt == ADDR_BITS'(ADN)) stateNext = wrenL ? WR_DONE : RD_WAIT;
      WR_DONE: begin
        tmoInc = 1'b1;
        if (s_ready) stateNext = RESP;
        else if (timedOut) begin
          stateNext = RESP;
          errNext = 1'b1;
        end
      end
      RD_WAIT: begin
        tmoInc = !s_hold;
        if (s_rvalid) stateNext = RD_SHIFT;
        else if (timedOut) begin
          stateNext = RESP;
          errNext = 1'b1;
        end
      end
      RD_SHIFT: begin
        if (!s_rvalid) begin
          stateNext = RESP;
          errNext = 1'b1;
        end else if (desCnt == DATA_BITS'(N - 1)) begin
          stateNext = RESP;
        end
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Include the bit being shifted in on the same edge that enters RESP.
  always_comb begin
    rdNext = desPar;
    if (wrenL) rdNext = '0;
    else if (desShift) rdNext = {desPar[N-2:0], s_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wrenL <= 1'b0;
      tmo <= '0;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      bus_req <= 1'b0;
      s_valid <= 1'b0;
      s_wren <= 1'b0;
      s_addr <= 1'b0;
      s_wdata <= 1'b0;
      s_bus_avail <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) wrenL <= req_wren;
      if (stateNext != state) tmo <= '0;
      else if (tmoInc && !timedOut) tmo <= tmo + 1'b1;
      req_ready <= (stateNext == IDLE);
      resp_valid <= (stateNext == RESP);
      bus_req <= stateNext inside {GRANT, START, SHIFT, WR_DONE, RD_WAIT, RD_SHIFT};
      s_valid <= stateNext inside {START, SHIFT};
      s_wren <= (stateNext inside {START, SHIFT}) && wrenL;
      s_addr <= serShift ? serOut[0] : START_BEAT;
      s_wdata <= serShift ? serOut[1] : 1'b0;
      s_bus_avail <= stateNext inside {RD_WAIT, RD_SHIFT};
      if (accept) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end else if (stateNext == RESP) begin
        resp_rdata <= rdNext;
        resp_err <= errNext;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboarded bench for bus_master_port with a behavioural serial BRAM slave.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int N = 8;
  localparam int ADN = 12;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_wren = 1'b0;
  logic [ADN-1:0] req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, bus_req;
  logic [N-1:0] resp_rdata;
  logic bus_grant = 1'b1;
  logic s_valid, s_wren, s_addr, s_wdata, s_bus_avail;
  logic s_ready = 1'b1, s_hold = 1'b0, s_rvalid = 1'b0, s_rdata = 1'b0;

  bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .s_valid(s_valid), .s_wren(s_wren), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_bus_avail(s_bus_avail),
    .s_ready(s_ready), .s_hold(s_hold), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural slave: samples master lines on negedge, drives its outputs there too.
  logic [N-1:0] mem [0:(1<<ADN)-1];
  int slPhase = 0, slCnt = 0, slOut = 0, slBeats = 0;
  int slLimit = N;
  logic [ADN-1:0] slAddr, slWd;
  logic [N-1:0] slData;
  logic slWren, slStartAddr, slStartWren, slWrenAll, slWrenAny;
  logic slValidSeen = 1'b0, slAvailOk = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      s_ready = 1'b1; s_hold = 1'b0; s_rvalid = 1'b0; s_rdata = 1'b0; slPhase = 0;
    end else begin
      case (slPhase)
        0: if (s_valid) begin
          slPhase = 1; s_ready = 1'b0; slBeats = 0; slAddr = '0; slWd = '0;
          slStartAddr = s_addr; slStartWren = s_wren; slWren = s_wren;
          slWrenAll = 1'b1; slWrenAny = 1'b0; slValidSeen = 1'b1;
        end
        1: if (s_valid) begin
          slBeats++;
          slAddr = {slAddr[ADN-2:0], s_addr};
          slWd = {slWd[ADN-2:0], s_wdata};
          slWrenAll &= s_wren;
          slWrenAny |= s_wren;
        end else if (slWren) begin
          mem[slAddr] = slWd[N-1:0]; slCnt = 2; slPhase = 2;
        end else begin
          s_hold = 1'b1; slCnt = DEF_DELAY_N; slPhase = 3;
        end
        2: if (slCnt == 0) begin s_ready = 1'b1; slPhase = 0; end else slCnt--;
        3: if (slCnt <= 1) begin
          // Preamble carries a 1 so a master that keeps it is visible in rdata.
          s_hold = 1'b0; s_rvalid = 1'b1; s_rdata = 1'b1; slOut = 0; slPhase = 4;
          slData = mem[slAddr];
        end else slCnt--;
        4: if (slOut < slLimit) begin
          if (!s_bus_avail) slAvailOk = 1'b0;
          s_rdata = slData[N-1-slOut]; slOut++;
        end else begin
          s_rvalid = 1'b0; s_rdata = 1'b0; s_ready = 1'b1; slPhase = 0;
        end
        default: slPhase = 0;
      endcase
    end
  end

  logic [N:0] expQ[$];
  string tagQ[$];
  int respCnt = 0, respCyc = 0;
  logic busReqAtResp;

  always @(negedge clk) begin
    if (resp_valid) begin
      respCnt++; respCyc = cyc; busReqAtResp = bus_req;
      if (expQ.size() > 0) begin
        logic [N:0] e;
        string t;
        e = expQ.pop_front();
        t = tagQ.pop_front();
        chk({t, "_rdata"}, resp_rdata, e[N-1:0]);
        chk({t, "_err"}, resp_err, e[N]);
      end
    end
  end

  task automatic issue(input logic wr, input logic [ADN-1:0] a, input logic [N-1:0] d,
                       input logic [N-1:0] expR, input logic expE, input bit doPush,
                       input string tag, output int accCyc);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wren = wr; req_addr = a; req_wdata = d;
    if (doPush) begin expQ.push_back({expE, expR}); tagQ.push_back(tag); end
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, req_ready, 1);
    @(posedge clk); #1;
    accCyc = cyc;
    req_valid = 1'b0; req_wren = ~wr;
    req_addr = ADN'($urandom); req_wdata = N'($urandom);
  endtask

  task automatic waitResp(input int base, input int limit, input string tag);
    int n = 0;
    while (respCnt == base && n < limit) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_resp_count"}, respCnt - base, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, base, sv, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // Write 0xA5 to 0x3C7, grant immediate
    base = respCnt;
    issue(1'b1, 12'h3C7, 8'hA5, 8'h00, 1'b0, 1, "wr1", acc);
    waitResp(base, 200, "wr1");
    chk("wr1_start_addr", slStartAddr, 0);
    chk("wr1_start_wren", slStartWren, 1);
    chk("wr1_beats", slBeats, ADN);
    chk("wr1_addr_stream", slAddr, 12'h3C7);
    chk("wr1_wdata_stream", slWd, 12'h0A5);
    chk("wr1_wren_held", slWrenAll, 1);

    // Read it back through the slave's hold period
    base = respCnt;
    slAvailOk = 1'b1;
    issue(1'b0, 12'h3C7, 8'h00, 8'hA5, 1'b0, 1, "rd1", acc);
    waitResp(base, 300, "rd1");
    chk("rd1_addr_stream", slAddr, 12'h3C7);
    chk("rd1_wren_low", slWrenAny, 0);
    chk("rd1_bus_avail", slAvailOk, 1);

    // Grant withheld: timeout 256 cycles after accept
    base = respCnt;
    bus_grant = 1'b0;
    slValidSeen = 1'b0;
    issue(1'b0, 12'h100, 8'h00, 8'h00, 1'b1, 1, "tmo", acc);
    waitResp(base, 400, "tmo");
    chk("tmo_latency", respCyc - acc, 256);
    chk("tmo_bus_req_dropped", busReqAtResp, 0);
    chk("tmo_no_s_valid", slValidSeen, 0);
    bus_grant = 1'b1;

    // Slave drops s_rvalid after 4 data bits
    base = respCnt;
    slLimit = 4;
    issue(1'b0, 12'h3C7, 8'h00, 8'h0A, 1'b1, 1, "drop", acc);
    waitResp(base, 300, "drop");
    slLimit = N;

    // Back-to-back: second request held while busy
    base = respCnt;
    issue(1'b1, 12'h05A, 8'h3C, 8'h00, 1'b0, 1, "b2b_wr", acc);
    issue(1'b0, 12'h05A, 8'h00, 8'h3C, 1'b0, 1, "b2b_rd", acc);
    chk("b2b_order", respCnt - base, 1);
    waitResp(base + 1, 300, "b2b_rd");

    // Reset during SHIFT beat 6
    base = respCnt;
    issue(1'b1, 12'h155, 8'h66, 8'h00, 1'b0, 0, "rstmid", acc);
    sv = 0; n = 0;
    while (sv < 7 && n < 100) begin @(negedge clk); if (s_valid) sv++; n++; end
    chk("rstmid_reach_beat6", sv, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_s_valid", s_valid, 0);
    chk("rstmid_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    chk("rstmid_bus_req", bus_req, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_ready_after", req_ready, 1);
    chk("rstmid_no_resp", respCnt - base, 0);

    chk("sb_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Parallel-to-serial bus master front end that sits directly upstream of the serial BRAM slave.
- Accepts one parallel read or write request from a core, arbitrates for the bus, and serialises address and write data onto the slave's 1-bit lines.
- For reads, waits out the slave's hold period, deserialises the returned byte, and presents a parallel response.
- Drives the slave's validIn, wren, Address, DataIn and BusAvailable inputs; consumes its ready, hold, validOut and DataOut outputs.

Parameters:
- N, 8: data width; must equal the slave's N.
- ADN, 12: address length; must equal the slave's ADN; ADN > N.
- TIMEOUT, 255: maximum cycles to wait for grant, slave ready, or read data before aborting with an error.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request strobe
- req_wren  in  1  1 = write, 0 = read
- req_addr  in  ADN  target address
- req_wdata  in  N  write data
- req_ready  out  1  master idle; request accepted when req_valid && req_ready
- resp_valid  out  1  one-cycle pulse: transaction finished
- resp_rdata  out  N  read data, valid with resp_valid on reads (0 on writes)
- resp_err  out  1  timeout flag, valid with resp_valid
- bus_req  out  1  request to arbiter
- bus_grant  in  1  arbiter grant
- s_valid  out  1  to slave validIn
- s_wren  out  1  to slave wren
- s_addr  out  1  to slave Address, MSB first
- s_wdata  out  1  to slave DataIn, MSB first
- s_bus_avail  out  1  to slave BusAvailable
- s_ready  in  1  slave ready
- s_hold  in  1  slave hold (read latency in progress)
- s_rvalid  in  1  slave validOut
- s_rdata  in  1  slave DataOut

Behaviour:
- Reset: synchronous, active-high; all registered outputs 0, req_ready 0 during rst, FSM to IDLE.
- All outputs are registered. Request fields are latched on acceptance; later changes on req_* are ignored.
- IDLE: req_ready=1. On accept → GRANT.
- GRANT: bus_req=1; wait for bus_grant && s_ready → START; timeout → RESP with resp_err=1.
- START: one cycle, s_valid=1, s_wren=latched wren, s_addr=0 (start beat, ignored by slave) → SHIFT.
- SHIFT: ADN cycles, s_valid=1, s_wren held, s_addr = address bit ADN-1 down to 0.
  - Write: s_wdata = wdata bit N-1 down to 0 during the last N beats (beats ADN-N+1..ADN); 0 otherwise.
  - After beat ADN, s_valid=0. Write → WR_DONE; read → RD_WAIT.
- WR_DONE: wait for s_ready high (slave has committed to BRAM) → RESP with rdata=0, err=0; timeout → RESP err.
- RD_WAIT: s_bus_avail=1 from this state through RD_SHIFT. s_wren=0, s_valid=0. Wait for the first s_rvalid=1 cycle; it is the preamble beat and its data is discarded → RD_SHIFT.
  - s_hold is informational only: it gates the timeout counter off while high.
  - Timeout otherwise → RESP err.
- RD_SHIFT: N cycles; shift in s_rdata MSB first, sampled only when s_rvalid=1.
  - If s_rvalid drops before N bits are captured → RESP with err=1, rdata = partial shift.
  - After N bits → RESP.
- RESP: resp_valid=1 for exactly one cycle; bus_req dropped; → IDLE.
  - resp_rdata/resp_err hold until the next accept.
- bus_req is held from GRANT through RD_SHIFT/WR_DONE; loss of bus_grant mid-transaction is not checked (the arbiter must not revoke).
- Counters: bit counter clog2(ADN)+1 bits; timeout counter clog2(TIMEOUT+1) bits, cleared on every state change, saturating.
- rst mid-transaction aborts immediately: no resp_valid, s_valid=0 next cycle.
  - The slave is recovered by the system-level reset; no recovery sequence is issued.
- req_valid during a busy state: ignored; req_ready=0.

Decomposition:
- Shared package bus_pkg: state enum, START-beat constant, width helpers (ADDR_BITS, CNT_BITS), default N/ADN/DelayN shared with the slave.
- One natural sub-module, bus_piso_sipo: a reusable shift register with load/shift-out/shift-in and a bit counter. It is used once for the address/wdata serialiser and once for the rdata deserialiser.

Test Plan:
- Write 0xA5 to addr 0x3C7 with grant immediate; slave idle → START, then 12 address beats 0011_1100_0111, wdata 10100101 on beats 5..12, resp_valid with err=0 after slave ready.
- Write 0xA5 to 0x3C7, then read 0x3C7 against the real slave (DelayN=20) → hold high ~20 cycles, preamble discarded, resp_rdata=0xA5, err=0.
- Read with bus_grant withheld 300 cycles (TIMEOUT=255) → resp_valid with err=1 at cycle 256 after accept; bus_req dropped; s_valid never asserted.
- Read where a slave model drops s_rvalid after 4 bits → err=1, resp_rdata=partial value.
- Back-to-back: second req_valid held while busy → not accepted until req_ready; two correct responses in order.
- Assert rst during SHIFT beat 6 → next cycle s_valid=0, req_ready=0 during reset then 1, no resp_valid emitted.
